// File: rtl/pulse_train_sequencer.sv
`default_nettype none
// =============================================================================
// pulse_train_sequencer : issues one generator start handshake per pulse of a
// configured burst and enforces the pulse repetition period.
// Revision: 1.0
// =============================================================================
module pulse_train_sequencer #(
  parameter logic [13:0] _CYCLES_PER_US = 14'd13000,
  parameter logic [3:0]  _ACK_TIMEOUT   = 4'd8
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        CFG_VALID,
  output logic        CFG_READY,
  input  logic [1:0]  CFG_SIGNAL_TYPE,
  input  logic [9:0]  CFG_T_IMPULSE,
  input  logic [15:0] CFG_T_PERIOD,
  input  logic [7:0]  CFG_N_PULSES,
  input  logic        ABORT,
  input  logic        OUT_REG_READY,
  input  logic        GEN_START_CALC,
  input  logic        GEN_STOP_CALC,
  output logic [1:0]  SIGNAL_TYPE,
  output logic [9:0]  T_IMPULSE,
  output logic        SIGN_START_GEN,
  output logic        BUSY,
  output logic [7:0]  PULSE_CNT,
  output logic        DONE,
  output logic        ERROR
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ARM      = 3'd1,
    S_START    = 3'd2,
    S_WAIT_ACK = 3'd3,
    S_RUN      = 3'd4,
    S_GAP      = 3'd5,
    S_DRAIN    = 3'd6,
    S_FIN      = 3'd7
  } state_t;

  state_t      r_state;
  logic [29:0] r_period;
  logic [7:0]  r_n_pulses;
  logic [31:0] r_pcnt;

  logic [29:0] w_cfg_period;
  logic [31:0] w_gap_thr;
  logic [31:0] w_ovr_thr;
  logic [31:0] w_ack_thr;
  logic [7:0]  w_cnt_next;
  logic        w_gap_due;
  logic        w_overrun;
  logic        w_ack_expired;

  assign w_cfg_period = {14'd0, CFG_T_PERIOD} * {16'd0, _CYCLES_PER_US};

  // pcnt reads 0 the cycle after START, so P-2 in GAP yields a strobe exactly P cycles later
  assign w_gap_thr = (r_period >= 30'd2) ? {2'b00, r_period - 30'd2} : 32'd0;
  assign w_ovr_thr = (r_period != 30'd0) ? {2'b00, r_period - 30'd1} : 32'd0;
  assign w_ack_thr = (_ACK_TIMEOUT >= 4'd2) ? {28'd0, _ACK_TIMEOUT - 4'd2} : 32'd0;

  assign w_cnt_next    = PULSE_CNT + 8'd1;
  assign w_gap_due     = (r_pcnt >= w_gap_thr);
  assign w_overrun     = (r_pcnt >= w_ovr_thr);
  assign w_ack_expired = (r_pcnt >= w_ack_thr);

  assign CFG_READY = (r_state == S_IDLE);
  assign BUSY      = (r_state != S_IDLE);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state        <= S_IDLE;
      r_period       <= '0;
      r_n_pulses     <= '0;
      r_pcnt         <= '0;
      SIGNAL_TYPE    <= '0;
      T_IMPULSE      <= '0;
      SIGN_START_GEN <= 1'b0;
      PULSE_CNT      <= '0;
      DONE           <= 1'b0;
      ERROR          <= 1'b0;
    end else begin
      SIGN_START_GEN <= 1'b0;
      DONE           <= 1'b0;

      if (r_state == S_START) begin
        r_pcnt <= '0;
      end else if (r_pcnt != '1) begin
        r_pcnt <= r_pcnt + 32'd1;
      end

      case (r_state)
        S_IDLE: begin
          if (CFG_VALID) begin
            SIGNAL_TYPE <= CFG_SIGNAL_TYPE;
            T_IMPULSE   <= CFG_T_IMPULSE;
            r_n_pulses  <= CFG_N_PULSES;
            r_period    <= w_cfg_period;
            PULSE_CNT   <= '0;
            ERROR       <= 1'b0;
            if (CFG_N_PULSES == 8'd0) begin
              r_state <= S_FIN;
              DONE    <= 1'b1;
            end else begin
              r_state <= S_ARM;
            end
          end
        end
        S_ARM: begin
          if (ABORT) begin
            r_state <= S_IDLE;
          end else if (OUT_REG_READY) begin
            r_state        <= S_START;
            SIGN_START_GEN <= 1'b1;
          end
        end
        S_START: begin
          r_state <= ABORT ? S_DRAIN : S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          // An acknowledge on the deadline cycle still wins over the timeout
          if (GEN_START_CALC) begin
            r_state <= ABORT ? S_DRAIN : S_RUN;
          end else if (w_ack_expired) begin
            r_state <= S_IDLE;
            if (!ABORT) begin
              ERROR <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (GEN_STOP_CALC) begin
            PULSE_CNT <= w_cnt_next;
            if (ABORT) begin
              r_state <= S_IDLE;
            end else if (w_cnt_next == r_n_pulses) begin
              r_state <= S_FIN;
              DONE    <= 1'b1;
            end else begin
              r_state <= S_GAP;
            end
          end else if (ABORT) begin
            r_state <= S_DRAIN;
          end else if (w_overrun) begin
            ERROR   <= 1'b1;
            r_state <= S_DRAIN;
          end
        end
        S_GAP: begin
          if (ABORT) begin
            r_state <= S_IDLE;
          end else if (w_gap_due && OUT_REG_READY) begin
            r_state        <= S_START;
            SIGN_START_GEN <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (GEN_STOP_CALC) begin
            r_state <= S_IDLE;
          end
        end
        S_FIN: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pulse_train_sequencer.sv
`default_nettype none
// =============================================================================
// tb_pulse_train_sequencer : directed and randomized bursts against an
// event-level reference model of the burst schedule.
// Revision: 1.0
// =============================================================================
module tb_pulse_train_sequencer;

  localparam logic [13:0] CPU    = 14'd10;
  localparam int          ACK_TO = 8;
  localparam int          MAXC   = 1500;
  localparam int          NONE   = 1000000;

  logic        CLK;
  logic        RESET;
  logic        CFG_VALID;
  logic        CFG_READY;
  logic [1:0]  CFG_SIGNAL_TYPE;
  logic [9:0]  CFG_T_IMPULSE;
  logic [15:0] CFG_T_PERIOD;
  logic [7:0]  CFG_N_PULSES;
  logic        ABORT;
  logic        OUT_REG_READY;
  logic        GEN_START_CALC;
  logic        GEN_STOP_CALC;
  logic [1:0]  SIGNAL_TYPE;
  logic [9:0]  T_IMPULSE;
  logic        SIGN_START_GEN;
  logic        BUSY;
  logic [7:0]  PULSE_CNT;
  logic        DONE;
  logic        ERROR;

  pulse_train_sequencer #(
    ._CYCLES_PER_US(CPU),
    ._ACK_TIMEOUT  (4'd8)
  ) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .CFG_VALID      (CFG_VALID),
    .CFG_READY      (CFG_READY),
    .CFG_SIGNAL_TYPE(CFG_SIGNAL_TYPE),
    .CFG_T_IMPULSE  (CFG_T_IMPULSE),
    .CFG_T_PERIOD   (CFG_T_PERIOD),
    .CFG_N_PULSES   (CFG_N_PULSES),
    .ABORT          (ABORT),
    .OUT_REG_READY  (OUT_REG_READY),
    .GEN_START_CALC (GEN_START_CALC),
    .GEN_STOP_CALC  (GEN_STOP_CALC),
    .SIGNAL_TYPE    (SIGNAL_TYPE),
    .T_IMPULSE      (T_IMPULSE),
    .SIGN_START_GEN (SIGN_START_GEN),
    .BUSY           (BUSY),
    .PULSE_CNT      (PULSE_CNT),
    .DONE           (DONE),
    .ERROR          (ERROR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Per-cycle OUT_REG_READY pattern, cycle 0 = configuration transfer cycle
  bit rdy [0:MAXC-1];

  // Expected event schedule, all cycles relative to the transfer cycle
  int e_str[$];
  int e_inc[$];
  int e_done;
  int e_idle;
  int e_err;

  task automatic fill_rdy_all();
    for (int t = 0; t < MAXC; t++) rdy[t] = 1'b1;
  endtask

  // Walks the burst as a sequence of waits: arm, start, ack window, pulse,
  // gap; the generator acks a cycles after each strobe and stops d later.
  // ABORT is held high from cycle ab onward.
  task automatic model(input int n, input int tper, input int a, input int d, input int ab);
    int p, othr, gthr, athr, s, cnt, run, drain, gap, nxt;
    e_str.delete();
    e_inc.delete();
    e_done = -1;
    e_idle = -1;
    e_err  = -1;
    p    = tper * int'(CPU);
    othr = (p > 0) ? p - 1 : 0;
    gthr = (p >= 2) ? p - 2 : 0;
    athr = ACK_TO - 2;
    if (n == 0) begin
      e_done = 1;
      e_idle = 2;
      return;
    end
    s = -1;
    for (int t = 1; t < MAXC; t++) begin
      if (t >= ab) begin e_idle = t + 1; return; end
      if (rdy[t]) begin s = t + 1; break; end
    end
    cnt = 0;
    while (s > 0 && s < MAXC) begin
      run = -1; drain = -1; gap = -1; nxt = -1;
      e_str.push_back(s);
      if (s >= ab) begin
        drain = s + 1;
      end else begin
        for (int x = s + 1; x < MAXC; x++) begin
          if (a > 0 && x == s + a) begin
            if (x >= ab) drain = x + 1; else run = x + 1;
            break;
          end
          if (x - s - 1 >= athr) begin
            if (x < ab) e_err = x + 1;
            e_idle = x + 1;
            return;
          end
        end
      end
      if (run > 0) begin
        for (int x = run; x < MAXC; x++) begin
          if (x == s + a + d) begin
            cnt++;
            e_inc.push_back(x + 1);
            if (x >= ab) begin e_idle = x + 1; return; end
            if (cnt == n) begin e_done = x + 1; e_idle = x + 2; return; end
            gap = x + 1;
            break;
          end
          if (x >= ab) begin drain = x + 1; break; end
          if (x - s - 1 >= othr) begin e_err = x + 1; drain = x + 1; break; end
        end
      end
      if (drain > 0) begin
        e_idle = s + a + d + 1;
        return;
      end
      if (gap < 0) return;
      for (int x = gap; x < MAXC; x++) begin
        if (x >= ab) begin e_idle = x + 1; return; end
        if (x - s - 1 >= gthr && rdy[x]) begin nxt = x + 1; break; end
      end
      s = nxt;
    end
  endtask

  task automatic run_burst(input string nm, input logic [1:0] ty, input logic [9:0] ti,
                           input int tper, input int n, input int a, input int d, input int ab);
    int pend_ack, pend_stop, lim, si, ii;
    bit exp_str;
    model(n, tper, a, d, ab);
    @(negedge CLK);
    check_eq({nm, " cfg_ready"}, 32'(CFG_READY), 32'd1);
    CFG_VALID       = 1'b1;
    CFG_SIGNAL_TYPE = ty;
    CFG_T_IMPULSE   = ti;
    CFG_T_PERIOD    = 16'(tper);
    CFG_N_PULSES    = 8'(n);
    ABORT           = 1'b0;
    OUT_REG_READY   = rdy[0];
    GEN_START_CALC  = 1'b0;
    GEN_STOP_CALC   = 1'b0;
    pend_ack  = -1;
    pend_stop = -1;
    si = 0;
    ii = 0;
    lim = (e_idle > 0) ? e_idle + 3 : MAXC - 1;
    for (int c = 1; (c <= lim + 5) || (c <= pend_stop); c++) begin
      @(negedge CLK);
      CFG_VALID = 1'b0;
      if (c <= lim) begin
        exp_str = (si < e_str.size()) && (e_str[si] == c);
        if (exp_str) si++;
        while (ii < e_inc.size() && e_inc[ii] <= c) ii++;
        check_eq($sformatf("%s strobe c%0d", nm, c), 32'(SIGN_START_GEN), 32'(exp_str));
        check_eq($sformatf("%s done c%0d", nm, c), 32'(DONE), 32'(c == e_done));
        check_eq($sformatf("%s cfg_ready c%0d", nm, c), 32'(CFG_READY), 32'(e_idle > 0 && c >= e_idle));
        check_eq($sformatf("%s busy c%0d", nm, c), 32'(BUSY), 32'(!(e_idle > 0 && c >= e_idle)));
        check_eq($sformatf("%s error c%0d", nm, c), 32'(ERROR), 32'(e_err > 0 && c >= e_err));
        check_eq($sformatf("%s pulse_cnt c%0d", nm, c), 32'(PULSE_CNT), 32'(ii));
        check_eq($sformatf("%s type c%0d", nm, c), 32'(SIGNAL_TYPE), 32'(ty));
        check_eq($sformatf("%s t_imp c%0d", nm, c), 32'(T_IMPULSE), 32'(ti));
      end
      if (SIGN_START_GEN && a > 0) begin
        pend_ack  = c + a;
        pend_stop = c + a + d;
      end
      GEN_START_CALC = (c == pend_ack);
      GEN_STOP_CALC  = (c == pend_stop);
      OUT_REG_READY  = (c < MAXC) ? rdy[c] : 1'b1;
      ABORT          = (c >= ab) && (c <= lim);
    end
    check_eq({nm, " strobe_total"}, 32'(si), 32'(e_str.size()));
    ABORT          = 1'b0;
    GEN_START_CALC = 1'b0;
    GEN_STOP_CALC  = 1'b0;
  endtask

  task automatic reset_mid_run();
    fill_rdy_all();
    @(negedge CLK);
    CFG_VALID       = 1'b1;
    CFG_SIGNAL_TYPE = 2'd3;
    CFG_T_IMPULSE   = 10'd2;
    CFG_T_PERIOD    = 16'd5;
    CFG_N_PULSES    = 8'd3;
    OUT_REG_READY   = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge CLK);
      CFG_VALID      = 1'b0;
      GEN_START_CALC = (c == 3) || (c == 53);
      GEN_STOP_CALC  = (c == 23);
    end
    check_eq("rst pre busy", 32'(BUSY), 32'd1);
    check_eq("rst pre pulse_cnt", 32'(PULSE_CNT), 32'd1);
    check_eq("rst pre type", 32'(SIGNAL_TYPE), 32'd3);
    #2 RESET = 1'b0;
    #1;
    check_eq("rst cfg_ready", 32'(CFG_READY), 32'd1);
    check_eq("rst busy", 32'(BUSY), 32'd0);
    check_eq("rst pulse_cnt", 32'(PULSE_CNT), 32'd0);
    check_eq("rst type", 32'(SIGNAL_TYPE), 32'd0);
    check_eq("rst t_imp", 32'(T_IMPULSE), 32'd0);
    check_eq("rst strobe", 32'(SIGN_START_GEN), 32'd0);
    check_eq("rst done", 32'(DONE), 32'd0);
    check_eq("rst error", 32'(ERROR), 32'd0);
    GEN_START_CALC = 1'b0;
    GEN_STOP_CALC  = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;
    repeat (5) @(negedge CLK);
  endtask

  initial begin
    int ty, ti, tper, n, a, d, ab;
    RESET           = 1'b0;
    CFG_VALID       = 1'b0;
    CFG_SIGNAL_TYPE = '0;
    CFG_T_IMPULSE   = '0;
    CFG_T_PERIOD    = '0;
    CFG_N_PULSES    = '0;
    ABORT           = 1'b0;
    OUT_REG_READY   = 1'b0;
    GEN_START_CALC  = 1'b0;
    GEN_STOP_CALC   = 1'b0;
    repeat (3) @(negedge CLK);
    check_eq("reset cfg_ready", 32'(CFG_READY), 32'd1);
    check_eq("reset busy", 32'(BUSY), 32'd0);
    check_eq("reset strobe", 32'(SIGN_START_GEN), 32'd0);
    check_eq("reset pulse_cnt", 32'(PULSE_CNT), 32'd0);
    check_eq("reset done", 32'(DONE), 32'd0);
    check_eq("reset error", 32'(ERROR), 32'd0);
    RESET = 1'b1;
    repeat (2) @(negedge CLK);

    fill_rdy_all();
    run_burst("normal", 2'd3, 10'd2, 5, 3, 1, 20, NONE);
    for (int t = 50; t <= 59; t++) rdy[t] = 1'b0;
    run_burst("backpressure", 2'd3, 10'd2, 5, 3, 1, 20, NONE);
    fill_rdy_all();
    run_burst("ack_timeout", 2'd1, 10'd7, 5, 3, 0, 20, NONE);
    run_burst("overrun", 2'd2, 10'd1, 1, 3, 1, 20, NONE);
    run_burst("abort_gap", 2'd3, 10'd2, 5, 3, 1, 20, 30);
    run_burst("abort_run", 2'd3, 10'd2, 5, 3, 1, 20, 10);
    run_burst("zero_pulses", 2'd1, 10'd5, 5, 0, 1, 20, NONE);
    run_burst("stop_on_deadline", 2'd0, 10'd3, 2, 2, 1, 18, NONE);
    reset_mid_run();

    for (int k = 0; k < 25; k++) begin
      ty   = int'($urandom_range(0, 3));
      ti   = int'($urandom_range(0, 1023));
      tper = int'($urandom_range(1, 8));
      n    = int'($urandom_range(0, 4));
      if ($urandom_range(0, 99) < 85) a = int'($urandom_range(1, 7));
      else a = int'($urandom_range(0, 2)) == 0 ? 0 : 7 + int'($urandom_range(1, 2));
      d    = int'($urandom_range(1, tper * 10 + 5));
      ab   = (a > 0 && $urandom_range(0, 99) < 30) ? int'($urandom_range(1, 60)) : NONE;
      for (int t = 0; t < MAXC; t++) rdy[t] = ($urandom_range(0, 4) != 0);
      run_burst($sformatf("rnd%0d", k), 2'(ty), 10'(ti), tper, n, a, d, ab);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
